// File: rtl/alu_instruction_cycle_if.sv
// alu_instruction_cycle_if: instruction ROM and data RAM bus of the accumulator core
interface alu_instruction_cycle_if #(
  parameter int INST_ADDR_WIDTH = 8,
  parameter int INST_DATA_WIDTH = 16,
  parameter int MEM_ADDR_WIDTH  = 8,
  parameter int MEM_DATA_WIDTH  = 8
);
  logic [INST_ADDR_WIDTH-1:0] rom_addr;
  logic [INST_DATA_WIDTH-1:0] rom_data;
  logic [MEM_ADDR_WIDTH-1:0]  ram_addr;
  logic [MEM_DATA_WIDTH-1:0]  ram_data_rd;
  logic [MEM_DATA_WIDTH-1:0]  ram_data_wr;
  logic                       ram_wr_en;
  modport master (
    output rom_addr, ram_addr, ram_data_wr, ram_wr_en,
    input  rom_data, ram_data_rd
  );
  modport slave (
    input  rom_addr, ram_addr, ram_data_wr, ram_wr_en,
    output rom_data, ram_data_rd
  );
endinterface

// File: rtl/alu_instruction_cycle.sv
// alu_instruction_cycle: two-stage fetch/execute 8-bit accumulator core with ALU and flags
module alu_instruction_cycle #(
  parameter int INST_ADDR_WIDTH = 8,
  parameter int INST_DATA_WIDTH = 16,
  parameter int MEM_ADDR_WIDTH  = 8,
  parameter int MEM_DATA_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      arst,
  alu_instruction_cycle_if.master   bus,
  output logic [MEM_DATA_WIDTH-1:0] acc,
  output logic [3:0]                flags
);
  localparam int MSB = MEM_DATA_WIDTH - 1;
  localparam logic [7:0] NOP = 8'h00, LDI = 8'h01, LD = 8'h02, ST = 8'h03;
  localparam logic [7:0] ADDI = 8'h04, ADD = 8'h05, SUBI = 8'h06, SUB = 8'h07;
  localparam logic [7:0] ANDI = 8'h08, AND = 8'h09, ORI = 8'h0A, OR = 8'h0B;
  localparam logic [7:0] XORI = 8'h0C, XOR = 8'h0D, NOT = 8'h0E, SHL = 8'h0F, SHR = 8'h10;
  localparam logic [7:0] JMP = 8'h18, JZ = 8'h19, JNZ = 8'h1A, JC = 8'h1B, JNC = 8'h1C;
  logic [INST_ADDR_WIDTH-1:0] pc;
  logic [INST_DATA_WIDTH-1:0] ir;
  logic                       valid;
  logic [7:0]                 op, k;
  logic                       mem_op, zn, take;
  logic [MEM_DATA_WIDTH-1:0]  opd, res;
  logic [MEM_DATA_WIDTH:0]    sum, dif;
  logic [3:0]                 flg;
  assign op = ir[INST_DATA_WIDTH-1 -: 8];
  assign k = ir[7:0];
  // register operands are the odd ALU opcodes ADD..XOR plus LD; everything else uses the immediate
  assign mem_op = op == LD || (op >= ADD && op <= XOR && op[0]);
  assign opd = mem_op ? bus.ram_data_rd : MEM_DATA_WIDTH'(k);
  assign sum = {1'b0, acc} + {1'b0, opd};
  assign dif = {1'b0, acc} - {1'b0, opd};
  assign zn = op != NOP && op != ST && op <= SHR;
  // branch conditions read the flags left by the previously completed instruction
  assign take = valid && (op == JMP || (op == JZ && flags[0]) || (op == JNZ && !flags[0]) ||
                          (op == JC && flags[1]) || (op == JNC && !flags[1]));
  assign bus.rom_addr = pc;
  assign bus.ram_addr = MEM_ADDR_WIDTH'(k);
  assign bus.ram_data_wr = acc;
  // a reset edge must never commit a store, so the strobe drops as soon as reset is seen
  assign bus.ram_wr_en = valid && op == ST && !arst;
  // ALU result and next flags {V,N,C,Z} for the instruction in execute
  always_comb begin
    res = acc;
    flg = flags;
    case (op)
      LDI, LD: res = opd;
      ADDI, ADD: begin
        res = sum[MSB:0];
        flg[1] = sum[MEM_DATA_WIDTH];
        flg[3] = acc[MSB] == opd[MSB] && res[MSB] != acc[MSB];
      end
      SUBI, SUB: begin
        res = dif[MSB:0];
        flg[1] = dif[MEM_DATA_WIDTH];
        flg[3] = acc[MSB] != opd[MSB] && res[MSB] != acc[MSB];
      end
      ANDI, AND: begin res = acc & opd; {flg[3], flg[1]} = 2'b00; end
      ORI, OR: begin res = acc | opd; {flg[3], flg[1]} = 2'b00; end
      XORI, XOR: begin res = acc ^ opd; {flg[3], flg[1]} = 2'b00; end
      NOT: begin res = ~acc; {flg[3], flg[1]} = 2'b00; end
      SHL: begin res = {acc[MSB-1:0], 1'b0}; flg[1] = acc[MSB]; flg[3] = 1'b0; end
      SHR: begin res = {1'b0, acc[MSB:1]}; flg[1] = acc[0]; flg[3] = 1'b0; end
      default: ;
    endcase
    if (zn) begin
      flg[2] = res[MSB];
      flg[0] = res == '0;
    end
  end
  // fetch stage: a taken jump redirects the PC and squashes the instruction fetched alongside it
  always_ff @(posedge clk) begin
    if (arst) begin
      pc <= '0;
      ir <= '0;
      valid <= 1'b0;
    end else begin
      pc <= take ? INST_ADDR_WIDTH'(k) : pc + INST_ADDR_WIDTH'(1);
      ir <= take ? '0 : bus.rom_data;
      valid <= !take;
    end
  end
  // execute stage: commit accumulator and flags for a valid instruction
  always_ff @(posedge clk) begin
    if (arst) begin
      acc <= '0;
      flags <= '0;
    end else if (valid) begin
      acc <= res;
      flags <= flg;
    end
  end
endmodule

// File: tb/tb_alu_instruction_cycle.sv
// tb_alu_instruction_cycle: directed and random program checks against an ISA-level model
module tb_alu_instruction_cycle;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic [7:0] acc;
  logic [3:0] flags;
  logic [15:0] rom [256];
  logic [7:0] ram [256];
  logic [7:0] m_ram [256];
  logic [7:0] ops [24] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                           8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
                           8'h10, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h13, 8'hFF};
  int n_cmp = 0, n_err = 0, wr_count = 0, base = 0;
  int m_acc, m_pc;
  bit mv, mn, mc, mz;

  alu_instruction_cycle_if bus();
  alu_instruction_cycle dut (.clk(clk), .arst(arst), .bus(bus), .acc(acc), .flags(flags));

  always #5 clk = ~clk;
  assign bus.rom_data = rom[bus.rom_addr];
  assign bus.ram_data_rd = ram[bus.ram_addr];
  always @(posedge clk) if (bus.ram_wr_en) begin
    ram[bus.ram_addr] = bus.ram_data_wr;
    wr_count++;
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin rom[i] = 16'h0000; ram[i] = 8'h00; end
  endtask
  task automatic start_reset();
    @(negedge clk); arst = 1'b1;
    @(posedge clk); @(negedge clk);
    clear_mem();
  endtask
  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); arst = 1'b0; base = wr_count;
  endtask
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // instruction-level interpreter: one execute slot per edge, a taken jump also burns a bubble slot
  task automatic model_run(input int slots);
    int pc, x, s, sa, sx;
    logic [7:0] op, k;
    bit take, upd;
    pc = 0; m_acc = 0; mv = 0; mn = 0; mc = 0; mz = 0;
    while (slots > 0) begin
      op = rom[pc][15:8]; k = rom[pc][7:0]; take = 0; upd = 0;
      x = (op == 8'h02 || op == 8'h05 || op == 8'h07 || op == 8'h09 || op == 8'h0B || op == 8'h0D) ? int'(m_ram[k]) : int'(k);
      sa = m_acc >= 128 ? m_acc - 256 : m_acc;
      sx = x >= 128 ? x - 256 : x;
      case (op)
        8'h01, 8'h02: begin m_acc = x; upd = 1; end
        8'h03: m_ram[k] = m_acc[7:0];
        8'h04, 8'h05: begin s = m_acc + x; mc = s > 255; mv = (sa + sx > 127) || (sa + sx < -128); m_acc = s % 256; upd = 1; end
        8'h06, 8'h07: begin mc = m_acc < x; mv = (sa - sx > 127) || (sa - sx < -128); m_acc = (m_acc - x + 256) % 256; upd = 1; end
        8'h08, 8'h09: begin m_acc = m_acc & x; mc = 0; mv = 0; upd = 1; end
        8'h0A, 8'h0B: begin m_acc = m_acc | x; mc = 0; mv = 0; upd = 1; end
        8'h0C, 8'h0D: begin m_acc = m_acc ^ x; mc = 0; mv = 0; upd = 1; end
        8'h0E: begin m_acc = 255 - m_acc; mc = 0; mv = 0; upd = 1; end
        8'h0F: begin mc = m_acc >= 128; m_acc = (m_acc * 2) % 256; mv = 0; upd = 1; end
        8'h10: begin mc = m_acc % 2 == 1; m_acc = m_acc / 2; mv = 0; upd = 1; end
        8'h18: take = 1;
        8'h19: take = mz;
        8'h1A: take = !mz;
        8'h1B: take = mc;
        8'h1C: take = !mc;
        default: ;
      endcase
      if (upd) begin mz = m_acc == 0; mn = m_acc >= 128; end
      pc = take ? int'(k) : (pc + 1) % 256;
      slots -= take ? 2 : 1;
    end
    m_pc = (pc + 1 + slots) % 256;
  endtask

  task automatic test_reset();
    start_reset(); rom[0] = 16'h0180; release_reset(); run(3);
    n_cmp++; if (acc !== 8'h80) begin n_err++; $display("FAIL pre_reset_acc: got %h want 80", acc); end
    arst = 1'b1; run(3);
    n_cmp++; if (bus.rom_addr !== 8'h00) begin n_err++; $display("FAIL reset_pc: got %h want 00", bus.rom_addr); end
    n_cmp++; if (acc !== 8'h00) begin n_err++; $display("FAIL reset_acc: got %h want 00", acc); end
    n_cmp++; if (flags !== 4'h0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", flags); end
    n_cmp++; if (bus.ram_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", bus.ram_wr_en); end
    arst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.rom_addr !== 8'(i)) begin n_err++; $display("FAIL release_pc%0d: got %h want %h", i, bus.rom_addr, 8'(i)); end
      run(1);
    end
  endtask

  task automatic test_add_overflow();
    start_reset(); rom[0] = 16'h017F; rom[1] = 16'h0401; rom[2] = 16'h0310; release_reset(); run(3);
    n_cmp++; if (acc !== 8'h80) begin n_err++; $display("FAIL add_acc: got %h want 80", acc); end
    n_cmp++; if (flags !== 4'b1100) begin n_err++; $display("FAIL add_flags: got %b want 1100", flags); end
    n_cmp++; if (bus.ram_wr_en !== 1'b1) begin n_err++; $display("FAIL st_wr_en_hi: got %b want 1", bus.ram_wr_en); end
    run(1);
    n_cmp++; if (bus.ram_wr_en !== 1'b0) begin n_err++; $display("FAIL st_wr_en_lo: got %b want 0", bus.ram_wr_en); end
    n_cmp++; if (ram[16] !== 8'h80) begin n_err++; $display("FAIL st_ram: got %h want 80", ram[16]); end
    run(3);
    n_cmp++; if (wr_count - base !== 1) begin n_err++; $display("FAIL st_pulses: got %0d want 1", wr_count - base); end
  endtask

  task automatic test_jz();
    start_reset();
    rom[0] = 16'h0105; rom[1] = 16'h0605; rom[2] = 16'h1920; rom[3] = 16'h0199; rom[32] = 16'h0411;
    release_reset(); run(3);
    n_cmp++; if (acc !== 8'h00) begin n_err++; $display("FAIL jz_sub_acc: got %h want 00", acc); end
    n_cmp++; if (flags !== 4'b0001) begin n_err++; $display("FAIL jz_sub_flags: got %b want 0001", flags); end
    run(1);
    n_cmp++; if (bus.rom_addr !== 8'h20) begin n_err++; $display("FAIL jz_target: got %h want 20", bus.rom_addr); end
    run(1);
    n_cmp++; if (acc !== 8'h00) begin n_err++; $display("FAIL jz_flush_acc: got %h want 00", acc); end
    n_cmp++; if (bus.rom_addr !== 8'h21) begin n_err++; $display("FAIL jz_next_pc: got %h want 21", bus.rom_addr); end
    run(1);
    n_cmp++; if (acc !== 8'h11) begin n_err++; $display("FAIL jz_target_exec: got %h want 11", acc); end
    n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL jz_target_flags: got %b want 0000", flags); end
  endtask

  task automatic test_jnc();
    start_reset();
    rom[0] = 16'h0103; rom[1] = 16'h0604; rom[2] = 16'h1C30; rom[3] = 16'h0401;
    release_reset(); run(3);
    n_cmp++; if (acc !== 8'hFF) begin n_err++; $display("FAIL borrow_acc: got %h want ff", acc); end
    n_cmp++; if (flags !== 4'b0110) begin n_err++; $display("FAIL borrow_flags: got %b want 0110", flags); end
    run(1);
    n_cmp++; if (bus.rom_addr !== 8'h04) begin n_err++; $display("FAIL jnc_not_taken_pc: got %h want 04", bus.rom_addr); end
    run(1);
    n_cmp++; if (acc !== 8'h00) begin n_err++; $display("FAIL jnc_fall_acc: got %h want 00", acc); end
    n_cmp++; if (flags !== 4'b0011) begin n_err++; $display("FAIL jnc_fall_flags: got %b want 0011", flags); end
  endtask

  task automatic test_back_to_back();
    start_reset();
    rom[0] = 16'h01A5; rom[1] = 16'h0305; rom[2] = 16'h0205; rom[3] = 16'h1000; ram[5] = 8'h3C;
    release_reset(); run(4);
    n_cmp++; if (acc !== 8'hA5) begin n_err++; $display("FAIL st_ld_acc: got %h want a5", acc); end
    n_cmp++; if (flags !== 4'b0100) begin n_err++; $display("FAIL st_ld_flags: got %b want 0100", flags); end
    n_cmp++; if (ram[5] !== 8'hA5) begin n_err++; $display("FAIL st_ld_ram: got %h want a5", ram[5]); end
    run(1);
    n_cmp++; if (acc !== 8'h52) begin n_err++; $display("FAIL shr_acc: got %h want 52", acc); end
    n_cmp++; if (flags !== 4'b0010) begin n_err++; $display("FAIL shr_flags: got %b want 0010", flags); end
  endtask

  task automatic test_reset_mid();
    start_reset(); rom[0] = 16'h0144; rom[1] = 16'h0308; ram[8] = 8'h11; release_reset(); run(2);
    n_cmp++; if (bus.ram_wr_en !== 1'b1) begin n_err++; $display("FAIL mid_st_pending: got %b want 1", bus.ram_wr_en); end
    arst = 1'b1; #1;
    n_cmp++; if (bus.ram_wr_en !== 1'b0) begin n_err++; $display("FAIL mid_wr_en_gated: got %b want 0", bus.ram_wr_en); end
    run(1);
    n_cmp++; if (ram[8] !== 8'h11) begin n_err++; $display("FAIL mid_no_write: got %h want 11", ram[8]); end
    n_cmp++; if (acc !== 8'h00) begin n_err++; $display("FAIL mid_acc: got %h want 00", acc); end
    n_cmp++; if (bus.rom_addr !== 8'h00) begin n_err++; $display("FAIL mid_pc: got %h want 00", bus.rom_addr); end
    n_cmp++; if (wr_count !== base) begin n_err++; $display("FAIL mid_pulses: got %0d want %0d", wr_count, base); end
    arst = 1'b0; run(4);
    n_cmp++; if (ram[8] !== 8'h44) begin n_err++; $display("FAIL restart_ram: got %h want 44", ram[8]); end
    n_cmp++; if (acc !== 8'h44) begin n_err++; $display("FAIL restart_acc: got %h want 44", acc); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int edges;
      logic [7:0] op, k;
      start_reset();
      for (int i = 0; i < 64; i++) begin
        op = ops[$urandom_range(0, 23)];
        k = 8'($urandom_range(0, 255));
        if (op >= 8'h18 && op <= 8'h1C) k = k % 64;
        else if (op == 8'h02 || op == 8'h03 || op[0]) k = k % 16;
        rom[i] = {op, k};
      end
      for (int i = 0; i < 16; i++) ram[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 256; i++) m_ram[i] = ram[i];
      edges = $urandom_range(8, 48);
      release_reset(); run(edges);
      model_run(edges - 1);
      n_cmp++; if (acc !== m_acc[7:0]) begin n_err++; $display("FAIL rand_acc[%0d]: got %h want %h", t, acc, m_acc[7:0]); end
      n_cmp++; if (flags !== {mv, mn, mc, mz}) begin n_err++; $display("FAIL rand_flags[%0d]: got %b want %b", t, flags, {mv, mn, mc, mz}); end
      n_cmp++; if (bus.rom_addr !== m_pc[7:0]) begin n_err++; $display("FAIL rand_pc[%0d]: got %h want %h", t, bus.rom_addr, m_pc[7:0]); end
      for (int i = 0; i < 16; i++) begin
        n_cmp++; if (ram[i] !== m_ram[i]) begin n_err++; $display("FAIL rand_ram[%0d][%0d]: got %h want %h", t, i, ram[i], m_ram[i]); end
      end
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_add_overflow();
    test_jz();
    test_jnc();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
